// File: rtl/snake_if.sv
// snake_if: game-input and display-query bus between the snake controller and its driver
interface snake_if;
  logic       Start;
  logic [3:0] Key_dir;
  logic [9:0] Pixel_x;
  logic [9:0] Pixel_y;
  logic [5:0] Apple_x;
  logic [4:0] Apple_y;
  logic [1:0] Object;
  logic       Apple_eaten;
  logic       Game_over;
  logic [4:0] Length;
  modport master (
    output Start, Key_dir, Pixel_x, Pixel_y, Apple_x, Apple_y,
    input  Object, Apple_eaten, Game_over, Length
  );
  modport slave (
    input  Start, Key_dir, Pixel_x, Pixel_y, Apple_x, Apple_y,
    output Object, Apple_eaten, Game_over, Length
  );
endinterface

// File: rtl/snake_ctrl.sv
// snake_ctrl: snake game state machine on a 40x30 cell grid with per-pixel cell classification
module snake_ctrl #(
  parameter int TICK_CYCLES = 12500000,
  parameter int MAX_LEN     = 16
) (
  input logic    Clk_25mhz,
  input logic    Rst_n,
  snake_if.slave bus
);
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, PLAY, DIE} state_t;
  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
  state_t        state_q, state_d;
  dir_t          dir_q, dir_d, pend_q, pend_d, key_dir;
  logic [TW-1:0] tick_q, tick_d;
  logic [5:0]    seg_x_q [MAX_LEN];
  logic [5:0]    seg_x_d [MAX_LEN];
  logic [4:0]    seg_y_q [MAX_LEN];
  logic [4:0]    seg_y_d [MAX_LEN];
  logic [4:0]    len_q, len_d;
  logic          eaten_q, eaten_d, over_q, over_d;
  logic [1:0]    obj_q, obj_d;
  logic          key_ok, move, eat, collide, body;
  logic [5:0]    nx, cx, cy;
  logic [4:0]    ny;
  // next-head arithmetic from the pending direction, eat/collision detection and key filtering
  always_comb begin
    key_dir = bus.Key_dir[3] ? UP : bus.Key_dir[2] ? DOWN : bus.Key_dir[1] ? LEFT : RIGHT;
    key_ok  = $onehot(bus.Key_dir) && key_dir != dir_t'(dir_q ^ 2'b01);
    move    = state_q == PLAY && tick_q == TW'(TICK_CYCLES - 1);
    nx      = seg_x_q[0] + 6'(pend_q == RIGHT) - 6'(pend_q == LEFT);
    ny      = seg_y_q[0] + 5'(pend_q == DOWN) - 5'(pend_q == UP);
    eat     = nx == bus.Apple_x && ny == bus.Apple_y;
    collide = nx == 6'd0 || nx == 6'd39 || ny == 5'd0 || ny == 5'd29;
    for (int i = 0; i < MAX_LEN; i++)
      if ((5'(i) + 5'd1 < len_q || (eat && 5'(i) < len_q)) && seg_x_q[i] == nx && seg_y_q[i] == ny)
        collide = 1'b1;
  end
  // pixel-to-cell classification: wall beats head beats live body; dead segments never match
  always_comb begin
    cx   = bus.Pixel_x[9:4];
    cy   = bus.Pixel_y[9:4];
    body = 1'b0;
    for (int i = 1; i < MAX_LEN; i++)
      if (5'(i) < len_q && seg_x_q[i] == cx && {1'b0, seg_y_q[i]} == cy) body = 1'b1;
    obj_d = (bus.Pixel_x >= 10'd640 || bus.Pixel_y >= 10'd480) ? 2'b00 :
            (cx == 6'd0 || cx == 6'd39 || cy == 6'd0 || cy == 6'd29) ? 2'b11 :
            (seg_x_q[0] == cx && {1'b0, seg_y_q[0]} == cy) ? 2'b01 :
            body ? 2'b10 : 2'b00;
  end
  // game FSM: tick pacing, direction latching, body shift/growth and restart reload
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    tick_d  = '0;
    len_d   = len_q;
    seg_x_d = seg_x_q;
    seg_y_d = seg_y_q;
    eaten_d = 1'b0;
    case (state_q)
      IDLE: state_d = bus.Start ? PLAY : IDLE;
      PLAY: begin
        tick_d = move ? '0 : tick_q + 1'b1;
        if (key_ok) pend_d = key_dir;
        if (move && collide) state_d = DIE;
        else if (move) begin
          dir_d = pend_q;
          for (int i = MAX_LEN - 1; i > 0; i--) begin
            seg_x_d[i] = seg_x_q[i-1];
            seg_y_d[i] = seg_y_q[i-1];
          end
          seg_x_d[0] = nx;
          seg_y_d[0] = ny;
          len_d      = (eat && len_q < 5'(MAX_LEN)) ? len_q + 5'd1 : len_q;
          eaten_d    = eat;
        end
      end
      DIE: if (bus.Start) begin
        state_d = IDLE;
        dir_d   = RIGHT;
        pend_d  = RIGHT;
        len_d   = 5'd3;
        for (int i = 0; i < MAX_LEN; i++) begin
          seg_x_d[i] = (i < 3) ? 6'(20 - i) : 6'd0;
          seg_y_d[i] = (i < 3) ? 5'd15 : 5'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    over_d = state_d == DIE;
  end
  // state and registered outputs; reset reloads the starting snake immediately
  always_ff @(posedge Clk_25mhz or negedge Rst_n)
    if (!Rst_n) begin
      state_q <= IDLE;
      dir_q   <= RIGHT;
      pend_q  <= RIGHT;
      tick_q  <= '0;
      len_q   <= 5'd3;
      eaten_q <= 1'b0;
      over_q  <= 1'b0;
      obj_q   <= 2'b00;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= (i < 3) ? 6'(20 - i) : 6'd0;
        seg_y_q[i] <= (i < 3) ? 5'd15 : 5'd0;
      end
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      tick_q  <= tick_d;
      len_q   <= len_d;
      eaten_q <= eaten_d;
      over_q  <= over_d;
      obj_q   <= obj_d;
      seg_x_q <= seg_x_d;
      seg_y_q <= seg_y_d;
    end
  assign bus.Object      = obj_q;
  assign bus.Apple_eaten = eaten_q;
  assign bus.Game_over   = over_q;
  assign bus.Length      = len_q;
endmodule

// File: tb/tb_snake_ctrl.sv
// tb_snake_ctrl: directed stimulus against a queue-based snake model compared every cycle
module tb_snake_ctrl;
  localparam int T = 4;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  int pulses;
  snake_if bus();
  snake_ctrl #(.TICK_CYCLES(T), .MAX_LEN(16)) dut (.Clk_25mhz(clk), .Rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int qx[$];
  int qy[$];
  int m_state, m_len, m_dx, m_dy, m_px, m_py, m_tick, kx, ky, nx, ny;
  bit key_ok, eat, hit;
  logic [1:0] e_obj;
  logic e_eat, e_over;
  logic [4:0] e_len;
  task automatic cmp(string name, logic [7:0] act, logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic m_init();
    qx = '{20, 19, 18};
    qy = '{15, 15, 15};
    m_len = 3; m_dx = 1; m_dy = 0; m_px = 1; m_py = 0; m_tick = 0;
  endtask
  function automatic logic [1:0] cell_obj(int px, int py);
    int cx, cy;
    cx = px / 16;
    cy = py / 16;
    if (px >= 640 || py >= 480) return 2'd0;
    if (cx == 0 || cx == 39 || cy == 0 || cy == 29) return 2'd3;
    if (qx[0] == cx && qy[0] == cy) return 2'd1;
    for (int i = 1; i < qx.size(); i++) if (qx[i] == cx && qy[i] == cy) return 2'd2;
    return 2'd0;
  endfunction
  // model: snake as a head-first queue of cells, state 0 idle / 1 play / 2 die
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_init();
      m_state = 0; e_obj = 0; e_eat = 0; e_over = 0; e_len = 3;
    end else begin
      e_obj = cell_obj(int'(bus.Pixel_x), int'(bus.Pixel_y));
      e_eat = 0;
      if (m_state == 0) begin
        if (bus.Start) m_state = 1;
      end else if (m_state == 2) begin
        if (bus.Start) begin m_state = 0; m_init(); end
      end else begin
        kx = (bus.Key_dir == 4'b0001) ? 1 : (bus.Key_dir == 4'b0010) ? -1 : 0;
        ky = (bus.Key_dir == 4'b0100) ? 1 : (bus.Key_dir == 4'b1000) ? -1 : 0;
        key_ok = $countones(bus.Key_dir) == 1 && !(kx == -m_dx && ky == -m_dy);
        if (m_tick == T - 1) begin
          m_tick = 0;
          nx = qx[0] + m_px;
          ny = qy[0] + m_py;
          eat = nx == int'(bus.Apple_x) && ny == int'(bus.Apple_y);
          hit = nx == 0 || nx == 39 || ny == 0 || ny == 29;
          for (int i = 0; i < (eat ? m_len : m_len - 1); i++) if (qx[i] == nx && qy[i] == ny) hit = 1;
          if (hit) m_state = 2;
          else begin
            m_dx = m_px; m_dy = m_py;
            qx.push_front(nx);
            qy.push_front(ny);
            if (eat && m_len < 16) m_len++;
            else begin void'(qx.pop_back()); void'(qy.pop_back()); end
            e_eat = eat;
          end
        end else m_tick++;
        if (key_ok) begin m_px = kx; m_py = ky; end
      end
      e_over = m_state == 2;
      e_len = 5'(m_len);
    end
  end
  // every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    cmp("object", bus.Object, e_obj);
    cmp("apple_eaten", bus.Apple_eaten, e_eat);
    cmp("game_over", bus.Game_over, e_over);
    cmp("length", bus.Length, e_len);
  end
  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic obj_at(string name, int x, int y, logic [1:0] exp);
    bus.Pixel_x = 10'(x);
    bus.Pixel_y = 10'(y);
    step();
    cmp(name, bus.Object, exp);
  endtask
  task automatic pulse_start();
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
  endtask
  task automatic wait_over(string name, int max);
    for (int i = 0; i < max && bus.Game_over !== 1'b1; i++) step();
    cmp(name, bus.Game_over, 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal;
  end
  initial begin
    bus.Start = 0; bus.Key_dir = 0; bus.Pixel_x = 0; bus.Pixel_y = 0; bus.Apple_x = 5; bus.Apple_y = 5;
    #1 rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    cmp("rst_length", bus.Length, 3);
    cmp("rst_over", bus.Game_over, 0);
    cmp("rst_object", bus.Object, 0);
    obj_at("idle_head", 320, 240, 1);
    obj_at("idle_body", 304, 240, 2);
    obj_at("idle_wall", 8, 8, 3);
    obj_at("idle_offscreen", 650, 10, 0);
    obj_at("idle_tail", 288, 240, 2);
    obj_at("idle_dead_seg", 272, 240, 0);
    bus.Pixel_x = 336; bus.Pixel_y = 240;
    pulse_start();
    step(4);
    obj_at("move1_head", 336, 240, 1);
    cmp("move1_len", bus.Length, 3);
    cmp("move1_over", bus.Game_over, 0);
    bus.Key_dir = 4'b0010; step();
    bus.Key_dir = 4'b1100; step();
    bus.Key_dir = 4'b0000; step();
    obj_at("reverse_ignored", 352, 240, 1);
    bus.Key_dir = 4'b1000; step();
    bus.Key_dir = 4'b0000; step(2);
    obj_at("turn_up_head", 352, 224, 1);
    obj_at("turn_up_neck", 352, 240, 2);
    pulse_start();
    cmp("start_in_play", bus.Game_over, 0);
    rst_n = 1'b0;
    step(2);
    bus.Apple_x = 22; bus.Apple_y = 15;
    rst_n = 1'b1;
    step();
    pulse_start();
    step(7);
    cmp("pre_eat", bus.Apple_eaten, 0);
    step();
    cmp("eat_pulse", bus.Apple_eaten, 1);
    cmp("eat_len", bus.Length, 4);
    step();
    cmp("eat_pulse_end", bus.Apple_eaten, 0);
    bus.Apple_x = 5; bus.Apple_y = 5;
    obj_at("eat_tail", 304, 240, 2);
    obj_at("eat_old_tail", 288, 240, 0);
    wait_over("wall_die", 200);
    cmp("die_len", bus.Length, 4);
    obj_at("die_head", 608, 240, 1);
    obj_at("die_wall", 624, 240, 3);
    obj_at("die_body", 592, 240, 2);
    step(8);
    obj_at("die_frozen", 608, 240, 1);
    pulse_start();
    cmp("restart_over", bus.Game_over, 0);
    cmp("restart_len", bus.Length, 3);
    obj_at("restart_head", 320, 240, 1);
    bus.Apple_x = 21; bus.Apple_y = 15;
    pulse_start();
    pulses = 0;
    for (int i = 0; i < 200 && bus.Game_over !== 1'b1; i++) begin
      bus.Apple_x = 6'(qx[0] + 1);
      step();
      pulses += int'(bus.Apple_eaten);
    end
    cmp("sat_die", bus.Game_over, 1);
    cmp("sat_len", bus.Length, 16);
    cmp("sat_pulses", 8'(pulses), 18);
    pulse_start();
    bus.Apple_x = 21; bus.Apple_y = 15;
    pulse_start();
    step(3);
    rst_n = 1'b0;
    #1;
    cmp("rst_move_eaten", bus.Apple_eaten, 0);
    cmp("rst_move_over", bus.Game_over, 0);
    cmp("rst_move_len", bus.Length, 3);
    cmp("rst_move_obj", bus.Object, 0);
    step(3);
    cmp("rst_hold_eaten", bus.Apple_eaten, 0);
    rst_n = 1'b1;
    step(6);
    obj_at("post_rst_head", 320, 240, 1);
    obj_at("post_rst_no_move", 336, 240, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
